dmem_access_unit: RTL and testbench

- Data-memory stage directly downstream of the ALU.
- Consumes the ALU result as a byte address and the second register operand as store data.
- Performs word loads and stores against an internal word array with a parameterised wait-state latency.
- Returns load data to writeback and holds the pipeline with a stall output while an access is in flight.

---
 rtl/dmem_pkg.sv | 13 +
 rtl/dmem_array.sv | 34 +++
 rtl/dmem_access_unit.sv | 133 +++++++++++++
 tb/tb_dmem_access_unit.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared state encoding and widths for the data-memory stage
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    WAIT = 2'b01,
    RESP = 2'b10
  } state_t;

  localparam int LAT_W  = 4;
  localparam int WORD_W = 32;

endpackage

// File: rtl/dmem_array.sv
// rtl/dmem_array.sv - word storage with synchronous write and registered read port
module dmem_array
  import dmem_pkg::*;
#(
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  we,
  input  logic                  re,
  input  logic                  rclr,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [WORD_W-1:0]     wdata,
  output logic [WORD_W-1:0]     rdata
);

  logic [WORD_W-1:0] mem [2**ADDR_WIDTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
  end

  // rclr lets stores and rejected accesses report zero through the same register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= rclr ? '0 : mem[addr];
    end
  end

endmodule

// File: rtl/dmem_access_unit.sv
// rtl/dmem_access_unit.sv - load/store stage with wait states; DMEM_ALIGN_CHECK_EN adds misalignment errors
module dmem_access_unit
  import dmem_pkg::*;
#(
  parameter int ADDR_WIDTH = 8,
  parameter int LATENCY    = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        req_ready,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        stall
);

  state_t                state, state_nxt;
  logic [LAT_W-1:0]      cnt, cnt_nxt;
  logic                  accept, commit;
  logic                  wr_q, err_q;
  logic [ADDR_WIDTH-1:0] idx_q;
  logic [WORD_W-1:0]     wdata_q;
  logic                  req_err;
  logic                  c_write, c_err;
  logic [ADDR_WIDTH-1:0] c_idx;
  logic [WORD_W-1:0]     c_wdata;
  logic                  unused_addr;

`ifdef DMEM_ALIGN_CHECK_EN
  assign req_err = |req_addr[1:0];
`else
  assign req_err = 1'b0;
`endif

  assign unused_addr = ^{req_addr[31:ADDR_WIDTH+2], req_addr[1:0]};

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    req_ready = 1'b0;
    stall     = 1'b0;
    accept    = 1'b0;
    commit    = 1'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        stall     = req_valid;
        if (req_valid) begin
          accept  = 1'b1;
          cnt_nxt = LAT_W'(LATENCY);
          if (LATENCY == 0) begin
            state_nxt = RESP;
            commit    = 1'b1;
          end else begin
            state_nxt = WAIT;
          end
        end
      end
      WAIT: begin
        stall   = 1'b1;
        cnt_nxt = cnt - LAT_W'(1);
        if (cnt == LAT_W'(1)) begin
          state_nxt = RESP;
          commit    = 1'b1;
        end
      end
      RESP: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      wr_q    <= 1'b0;
      err_q   <= 1'b0;
      idx_q   <= '0;
      wdata_q <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (accept) begin
        wr_q    <= req_write;
        err_q   <= req_err;
        idx_q   <= req_addr[ADDR_WIDTH+1:2];
        wdata_q <= req_wdata;
      end
    end
  end

  // With zero wait states the commit edge is the accept edge, so use the live request
  assign c_write = (state == IDLE) ? req_write                   : wr_q;
  assign c_err   = (state == IDLE) ? req_err                     : err_q;
  assign c_idx   = (state == IDLE) ? req_addr[ADDR_WIDTH+1:2]    : idx_q;
  assign c_wdata = (state == IDLE) ? req_wdata                   : wdata_q;

  dmem_array #(
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_array (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (commit & c_write & ~c_err),
    .re    (commit),
    .rclr  (c_write | c_err),
    .addr  (c_idx),
    .wdata (c_wdata),
    .rdata (resp_rdata)
  );

  assign resp_valid = (state == RESP);

`ifdef DMEM_ALIGN_CHECK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resp_err <= 1'b0;
    end else if (commit) begin
      resp_err <= c_err;
    end
  end
`else
  assign resp_err = 1'b0;
`endif

endmodule

// File: tb/tb_dmem_access_unit.sv
// tb/tb_dmem_access_unit.sv - bench for dmem_access_unit at LATENCY 2 and 0, honours DMEM_ALIGN_CHECK_EN
module tb_dmem_access_unit;

`ifdef DMEM_ALIGN_CHECK_EN
  localparam bit ALIGN = 1'b1;
`else
  localparam bit ALIGN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]       rv, rw, rdy, vld, err, stl;
  logic [1:0][31:0] ra, rwd, rdata;

  dmem_access_unit #(.ADDR_WIDTH(8), .LATENCY(2)) u_lat2 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(rv[0]), .req_write(rw[0]), .req_addr(ra[0]), .req_wdata(rwd[0]),
    .req_ready(rdy[0]), .resp_valid(vld[0]), .resp_rdata(rdata[0]),
    .resp_err(err[0]), .stall(stl[0])
  );

  dmem_access_unit #(.ADDR_WIDTH(8), .LATENCY(0)) u_lat0 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(rv[1]), .req_write(rw[1]), .req_addr(ra[1]), .req_wdata(rwd[1]),
    .req_ready(rdy[1]), .resp_valid(vld[1]), .resp_rdata(rdata[1]),
    .resp_err(err[1]), .stall(stl[1])
  );

  int errors = 0;
  int checks = 0;
  int rst_count = 0;

  function automatic int lat_of(input int k);
    return (k == 0) ? 2 : 0;
  endfunction

  task automatic chk(input string name, input int k, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s inst%0d t=%0t got=%h expected=%h", name, k, $time, got, exp);
    end
  endtask

  // Reference model: each access is a countdown of LATENCY+1 cycles; the array
  // effect is applied in the response cycle so a reset in between discards it.
  logic [31:0] mmem [2][256];
  bit          known [2][256];
  int          left [2];
  logic        pw [2];
  logic [31:0] pa [2];
  logic [31:0] pd [2];
  logic [31:0] last_rd [2];
  logic        last_err [2];
  bit          rd_known [2];
  int          seen_rst = 0;

  always @(negedge clk) begin
    if (rst_n) begin
      if (seen_rst != rst_count) begin
        seen_rst = rst_count;
        for (int k = 0; k < 2; k++) begin
          left[k] = 0;
          last_rd[k] = 32'h0;
          last_err[k] = 1'b0;
          rd_known[k] = 1'b1;
        end
      end
      for (int k = 0; k < 2; k++) begin
        logic e_rdy, e_stl, e_vld, me;
        int idx;
        e_vld = (left[k] == 1);
        e_rdy = (left[k] == 0);
        e_stl = (left[k] == 0) ? rv[k] : (left[k] > 1);
        if (left[k] == 1) begin
          me  = ALIGN && (pa[k][1:0] != 2'b00);
          idx = int'(pa[k][9:2]);
          if (pw[k]) begin
            if (!me) begin
              mmem[k][idx] = pd[k];
              known[k][idx] = 1'b1;
            end
            last_rd[k] = 32'h0;
            rd_known[k] = 1'b1;
          end else begin
            last_rd[k] = me ? 32'h0 : mmem[k][idx];
            rd_known[k] = me || known[k][idx];
          end
          last_err[k] = me;
        end
        chk("req_ready", k, 32'(rdy[k]), 32'(e_rdy));
        chk("stall", k, 32'(stl[k]), 32'(e_stl));
        chk("resp_valid", k, 32'(vld[k]), 32'(e_vld));
        chk("resp_err", k, 32'(err[k]), 32'(last_err[k]));
        if (rd_known[k]) chk("resp_rdata", k, rdata[k], last_rd[k]);
        if (left[k] > 0) begin
          left[k]--;
        end else if (rv[k]) begin
          left[k] = lat_of(k) + 1;
          pw[k] = rw[k];
          pa[k] = ra[k];
          pd[k] = rwd[k];
        end
      end
    end
  end

  task automatic access(input int k, input logic w, input logic [31:0] a, input logic [31:0] d,
                        output logic [31:0] rd, output logic er, output int lc, output int ns);
    @(posedge clk);
    #1;
    rv[k] = 1'b1; rw[k] = w; ra[k] = a; rwd[k] = d;
    @(negedge clk);
    ns = int'(stl[k]);
    @(posedge clk);
    #1;
    rv[k] = 1'b0;
    lc = 0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      lc++;
      ns += int'(stl[k]);
      if (vld[k]) break;
    end
    chk("resp_seen", k, 32'(vld[k]), 32'd1);
    rd = rdata[k];
    er = err[k];
  endtask

  logic [31:0] rd;
  logic        er;
  int          lc, ns, nresp, pick;
  logic [5:0]  sp, vp;
  logic [31:0] exp_err_rd, exp_after;
  logic        exp_err;

  initial begin
    rv = '0; rw = '0; ra = '0; rwd = '0;
    rst_count = 1;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      chk("reset_rdata", k, rdata[k], 32'h0);
      chk("reset_valid", k, 32'(vld[k]), 32'd0);
      chk("reset_ready", k, 32'(rdy[k]), 32'd1);
    end

    for (int k = 0; k < 2; k++) begin
      for (int w = 0; w < 17; w++) begin
        pick = (w < 16) ? w : 255;
        access(k, 1'b1, {22'($urandom), 8'(pick), 2'b00}, $urandom, rd, er, lc, ns);
      end
    end

    access(0, 1'b1, 32'h10, 32'hDEADBEEF, rd, er, lc, ns);
    chk("st_latency", 0, 32'(lc), 32'd3);
    chk("st_stall_cycles", 0, 32'(ns), 32'd3);
    chk("st_rdata", 0, rd, 32'h0);
    access(0, 1'b0, 32'h10, 32'h0, rd, er, lc, ns);
    chk("ld_latency", 0, 32'(lc), 32'd3);
    chk("ld_stall_cycles", 0, 32'(ns), 32'd3);
    chk("ld_data", 0, rd, 32'hDEADBEEF);
    chk("ld_err", 0, 32'(er), 32'd0);

    access(0, 1'b1, 32'h400, 32'h12345678, rd, er, lc, ns);
    access(0, 1'b0, 32'h0, 32'h0, rd, er, lc, ns);
    chk("wrap_data", 0, rd, 32'h12345678);

    access(0, 1'b1, 32'hFFFFFFFC, 32'h0BADCAFE, rd, er, lc, ns);
    access(0, 1'b0, 32'h3FC, 32'h0, rd, er, lc, ns);
    chk("top_word", 0, rd, 32'h0BADCAFE);

    access(0, 1'b1, 32'h20, 32'h11111111, rd, er, lc, ns);
    @(posedge clk);
    #1;
    rv[0] = 1'b1; rw[0] = 1'b1; ra[0] = 32'h20; rwd[0] = 32'hCAFEF00D;
    @(posedge clk);
    #1;
    rv[0] = 1'b0;
    @(negedge clk);
    #1;
    rst_count++;
    rst_n = 1'b0;
    #2 rst_n = 1'b1;
    nresp = 0;
    repeat (6) begin
      @(negedge clk);
      nresp += int'(vld[0]);
    end
    chk("rst_no_resp", 0, 32'(nresp), 32'd0);
    access(0, 1'b0, 32'h20, 32'h0, rd, er, lc, ns);
    chk("rst_store_dropped", 0, rd, 32'h11111111);

`ifdef DMEM_ALIGN_CHECK_EN
    exp_err = 1'b1; exp_err_rd = 32'h0; exp_after = 32'h55555555;
`else
    exp_err = 1'b0; exp_err_rd = 32'h0; exp_after = 32'hAAAAAAAA;
`endif
    access(0, 1'b1, 32'h40, 32'h55555555, rd, er, lc, ns);
    access(0, 1'b1, 32'h42, 32'hAAAAAAAA, rd, er, lc, ns);
    chk("misalign_err", 0, 32'(er), 32'(exp_err));
    chk("misalign_rdata", 0, rd, exp_err_rd);
    access(0, 1'b0, 32'h40, 32'h0, rd, er, lc, ns);
    chk("misalign_after", 0, rd, exp_after);

    access(1, 1'b1, 32'h40, 32'h13572468, rd, er, lc, ns);
    chk("l0_latency", 1, 32'(lc), 32'd1);
    chk("l0_stall_cycles", 1, 32'(ns), 32'd1);
    @(posedge clk);
    #1;
    rv[1] = 1'b1; rw[1] = 1'b0; ra[1] = 32'h40;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      sp[i] = stl[1];
      vp[i] = vld[1];
    end
    @(posedge clk);
    #1;
    rv[1] = 1'b0;
    chk("b2b_stall", 1, 32'(sp), 32'(6'b010101));
    chk("b2b_valid", 1, 32'(vp), 32'(6'b101010));
    chk("b2b_data", 1, rdata[1], 32'h13572468);

    for (int c = 0; c < 2000; c++) begin
      @(posedge clk);
      #1;
      for (int k = 0; k < 2; k++) begin
        rv[k] = ($urandom_range(0, 3) != 0);
        rw[k] = 1'($urandom_range(0, 1));
        pick = $urandom_range(0, 16);
        if (pick == 16) pick = 255;
        ra[k] = {22'($urandom), 8'(pick),
                 ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00};
        rwd[k] = $urandom;
      end
    end
    @(posedge clk);
    #1;
    rv = '0;
    repeat (10) @(posedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
